// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions.
//   PRESCALE_W_DEF : default width of prescale / edge counter buses
//   IDLE_LVL       : idle (mark) level of the serial line
//   cnt_width()    : width needed to hold a sample count of 0..n
//   popcount()     : number of set bits in an up-to-8-bit vector (majority vote helper)
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W_DEF = 5;
    localparam logic        IDLE_LVL       = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchroniser chain.
//   clk : destination clock
//   rst : asynchronous, active-low reset; all stages load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output; STAGES = 0 passes d straight through
module bit_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_bypass
        assign q = d;
    end else begin : g_chain
        logic [STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= {STAGES{RESET_VAL}};
            end else begin
                sync_q[0] <= d;
                for (int i = 1; i < STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign q = sync_q[STAGES-1];
    end

endmodule

// File: rtl/data_sampler_mv.sv
// UART RX oversampling data sampler with majority vote.
// Synchronises rx_in, captures NUM_SAMPLES consecutive samples centred on the bit midpoint and
// votes them at the last edge of the bit.
//   clk         : oversampling clock (prescale x baud)
//   rst         : asynchronous, active-low reset
//   rx_in       : serial line, idle high
//   prescale    : oversampling ratio; edge_cnt runs 0..prescale-1
//   dat_samp_en : sampling enable from the RX FSM
//   edge_cnt    : position inside the current bit
//   sampled_bit : majority-voted bit, held until the next strobe
//   sampled_vld : one-cycle strobe, sampled_bit updated this cycle
//   noise_err   : samples of the voted bit disagreed (qualified by sampled_vld)
//   cfg_err     : prescale too small for the sample window; sampling suppressed
module data_sampler_mv
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF,
    parameter int unsigned NUM_SAMPLES = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sampled_vld,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int unsigned HALF  = NUM_SAMPLES / 2;
    localparam int unsigned CNT_W = cnt_width(NUM_SAMPLES);

    if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES > 7) begin : g_bad_num_samples
        $error("data_sampler_mv: NUM_SAMPLES must be odd and in 1..7");
    end

    logic rx_s;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_LVL)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    logic [NUM_SAMPLES-1:0] samp_q, samp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bit_q, bit_d;
    logic                   vld_q, vld_d;
    logic                   noise_q, noise_d;
    logic                   cfg_err_q;

    // Sample window placement
    logic [PRESCALE_W-1:0] mid, start;
    logic [PRESCALE_W:0]   win_end;
    logic                  cfg_bad, active, in_range, take, evaluate;

    always_comb begin
        mid      = prescale >> 1;
        start    = (mid >= PRESCALE_W'(HALF)) ? mid - PRESCALE_W'(HALF) : '0;
        win_end  = {1'b0, start} + (PRESCALE_W+1)'(NUM_SAMPLES);
        cfg_bad  = {1'b0, prescale} < (PRESCALE_W+1)'(NUM_SAMPLES + 1);
        // The live compare covers the cycle before the registered flag catches up.
        active   = dat_samp_en & ~cfg_bad & ~cfg_err_q;
        in_range = edge_cnt < prescale;
        take     = active & in_range & (edge_cnt >= start) & ({1'b0, edge_cnt} < win_end);
        evaluate = active & in_range & (edge_cnt == prescale - PRESCALE_W'(1));
    end

    // Vote sees the sample taken this cycle when window end and evaluate coincide.
    logic [NUM_SAMPLES:0]   shift_full;
    logic [NUM_SAMPLES-1:0] samp_shift, vote_vec;
    logic [CNT_W-1:0]       cnt_inc, vote_cnt;
    logic [3:0]             ones;

    always_comb begin
        shift_full = {samp_q, rx_s};
        samp_shift = shift_full[NUM_SAMPLES-1:0];
        cnt_inc    = (cnt_q == CNT_W'(NUM_SAMPLES)) ? cnt_q : cnt_q + CNT_W'(1);
        vote_vec   = take ? samp_shift : samp_q;
        vote_cnt   = take ? cnt_inc : cnt_q;
        ones       = popcount(8'(vote_vec));
    end

    always_comb begin
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        vld_d   = 1'b0;
        noise_d = noise_q;
        if (!active) begin
            samp_d = '0;
            cnt_d  = '0;
        end else if (evaluate) begin
            samp_d = '0;
            cnt_d  = '0;
            // A partial bit (window not fully seen) produces no strobe.
            if (vote_cnt == CNT_W'(NUM_SAMPLES)) begin
                bit_d   = ones > 4'(HALF);
                vld_d   = 1'b1;
                noise_d = (ones != 4'd0) && (ones != 4'(NUM_SAMPLES));
            end
        end else if (take) begin
            samp_d = samp_shift;
            cnt_d  = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= IDLE_LVL;
            vld_q     <= 1'b0;
            noise_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            vld_q     <= vld_d;
            noise_q   <= noise_d;
            cfg_err_q <= cfg_bad;
        end
    end

    assign sampled_bit = bit_q;
    assign sampled_vld = vld_q;
    assign noise_err   = noise_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_data_sampler_mv.sv
// Bench for data_sampler_mv: two instances (3 and 5 samples per bit) share one stimulus stream.
// A per-bit sample-list model predicts every output each cycle; directed literals pin the model.
module tb_data_sampler_mv;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in, dat_samp_en;
    logic [4:0] prescale, edge_cnt;
    logic [1:0] sb, sv, ne, ce;

    always #5 clk = ~clk;

    data_sampler_mv #(.PRESCALE_W(5), .NUM_SAMPLES(3), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .dat_samp_en(dat_samp_en),
        .edge_cnt(edge_cnt), .sampled_bit(sb[0]), .sampled_vld(sv[0]), .noise_err(ne[0]),
        .cfg_err(ce[0])
    );

    data_sampler_mv #(.PRESCALE_W(5), .NUM_SAMPLES(5), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .dat_samp_en(dat_samp_en),
        .edge_cnt(edge_cnt), .sampled_bit(sb[1]), .sampled_vld(sv[1]), .noise_err(ne[1]),
        .cfg_err(ce[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ns(input int k);
        return (k == 0) ? 3 : 5;
    endfunction

    // ---------------- model ----------------
    bit   p1 = 1'b1, p2 = 1'b1;
    bit   mq[2][$];
    logic exp_bit[2]   = '{1'b1, 1'b1};
    logic exp_vld[2]   = '{1'b0, 1'b0};
    logic exp_noise[2] = '{1'b0, 1'b0};
    logic exp_cfg[2]   = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst) begin
        bit rxs, bad, sup;
        int n, half, mid, start, pre, ec, ones;
        if (!rst) begin
            p1 = 1'b1;
            p2 = 1'b1;
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                exp_bit[k]   = 1'b1;
                exp_vld[k]   = 1'b0;
                exp_noise[k] = 1'b0;
                exp_cfg[k]   = 1'b0;
            end
        end else begin
            rxs = p2;
            p2  = p1;
            p1  = rx_in;
            pre = int'(prescale);
            ec  = int'(edge_cnt);
            for (int k = 0; k < 2; k++) begin
                n     = ns(k);
                half  = n / 2;
                mid   = pre / 2;
                start = (mid >= half) ? mid - half : 0;
                bad   = pre < n + 1;
                sup   = bad || exp_cfg[k];
                exp_vld[k] = 1'b0;
                if (!dat_samp_en || sup) begin
                    mq[k].delete();
                end else if (ec < pre) begin
                    if (ec >= start && ec < start + n) begin
                        mq[k].push_back(rxs);
                        if (mq[k].size() > n) void'(mq[k].pop_front());
                    end
                    if (ec == pre - 1) begin
                        if (mq[k].size() == n) begin
                            ones = 0;
                            for (int i = 0; i < n; i++) ones += int'(mq[k][i]);
                            exp_bit[k]   = ones > half;
                            exp_noise[k] = (ones != 0) && (ones != n);
                            exp_vld[k]   = 1'b1;
                        end
                        mq[k].delete();
                    end
                end
                exp_cfg[k] = bad;
            end
        end
    end

    // ---------------- compare + strobe log ----------------
    bit lg_bit[2][$];
    bit lg_noise[2][$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bit[%0d]", k), sb[k], exp_bit[k]);
            chk($sformatf("vld[%0d]", k), sv[k], exp_vld[k]);
            chk($sformatf("cfg[%0d]", k), ce[k], exp_cfg[k]);
            if (exp_vld[k]) chk($sformatf("noise[%0d]", k), ne[k], exp_noise[k]);
            if (sv[k]) begin
                lg_bit[k].push_back(sb[k]);
                lg_noise[k].push_back(ne[k]);
            end
        end
    end

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            lg_bit[k].delete();
            lg_noise[k].delete();
        end
    endtask

    task automatic chk_log(input string name, input int k, input int n,
                           input logic [7:0] bits, input logic [7:0] noises);
        logic a;
        chk_int({name, "_count"}, lg_bit[k].size(), n);
        for (int i = 0; i < n; i++) begin
            a = (i < lg_bit[k].size()) ? lg_bit[k][i] : 1'bx;
            chk($sformatf("%s_bit%0d", name, i), a, bits[i]);
            a = (i < lg_noise[k].size()) ? lg_noise[k][i] : 1'bx;
            chk($sformatf("%s_noise%0d", name, i), a, noises[i]);
        end
    endtask

    // ---------------- stimulus lists ----------------
    // s_rx holds the value wanted on the synchronised line at that cycle.
    int s_pre[$], s_ec[$];
    bit s_en[$], s_rx[$];

    task automatic add(input int pre, input int ec, input bit en, input bit rx);
        s_pre.push_back(pre);
        s_ec.push_back(ec);
        s_en.push_back(en);
        s_rx.push_back(rx);
    endtask

    task automatic idle(input int pre, input int n);
        for (int i = 0; i < n; i++) add(pre, 0, 1'b0, 1'b1);
    endtask

    task automatic add_bit(input int pre, input bit base, input int flip, input int en_last);
        for (int e = 0; e < pre; e++) add(pre, e, e <= en_last, (e == flip) ? ~base : base);
    endtask

    task automatic play();
        for (int t = 0; t < s_pre.size(); t++) begin
            @(negedge clk);
            prescale    = 5'(s_pre[t]);
            edge_cnt    = 5'(s_ec[t]);
            dat_samp_en = s_en[t];
            rx_in       = (t + 2 < s_rx.size()) ? s_rx[t+2] : 1'b1;
        end
        s_pre.delete();
        s_ec.delete();
        s_en.delete();
        s_rx.delete();
    endtask

    task automatic go_idle();
        dat_samp_en = 1'b0;
        edge_cnt    = '0;
        rx_in       = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        rx_in       = 1'b1;
        prescale    = 5'd8;
        dat_samp_en = 1'b0;
        edge_cnt    = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bit", sb[0], 1'b1);
        chk("reset_vld", sv[0], 1'b0);
        chk("reset_cfg", ce[0], 1'b0);
        rst = 1'b1;

        // 1: all-zero bit, strobe the cycle after edge 7
        clear_logs();
        idle(8, 3);
        add_bit(8, 1'b0, -1, 7);
        play();
        @(negedge clk);
        chk("t1_vld_latency", sv[0], 1'b1);
        go_idle();
        idle(8, 2);
        play();
        chk_log("t1", 0, 1, 8'b0, 8'b0);

        // 2: 1,0,1 -> 1 noisy; 0,1,0 -> 0 noisy
        clear_logs();
        add_bit(8, 1'b1, 4, 7);
        add_bit(8, 1'b0, 4, 7);
        idle(8, 3);
        play();
        chk_log("t2a", 0, 2, 8'b01, 8'b11);
        chk_log("t2b", 1, 2, 8'b01, 8'b11);

        // 3: P=16 glitch at edge 8
        clear_logs();
        add_bit(16, 1'b1, 8, 15);
        idle(16, 3);
        play();
        chk_log("t3a", 0, 1, 8'b1, 8'b1);
        chk_log("t3b", 1, 1, 8'b1, 8'b1);

        // 4: enable dropped after edge 4, then a clean 1 bit
        clear_logs();
        add_bit(8, 1'b0, -1, 4);
        add_bit(8, 1'b1, -1, 7);
        idle(8, 3);
        play();
        chk_log("t4a", 0, 1, 8'b1, 8'b0);
        chk_log("t4b", 1, 1, 8'b1, 8'b0);

        // 5: reset mid-bit
        clear_logs();
        add_bit(8, 1'b0, -1, 7);
        for (int e = 0; e < 5; e++) add(8, e, 1'b1, 1'b0);
        play();
        @(negedge clk);
        chk("t5_pre_bit", sb[0], 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_bit", sb[0], 1'b1);
        chk("t5_rst_vld", sv[0], 1'b0);
        @(negedge clk);
        go_idle();
        rst = 1'b1;
        clear_logs();
        idle(8, 3);
        add_bit(8, 1'b0, -1, 7);
        idle(8, 3);
        play();
        chk_log("t5a", 0, 1, 8'b0, 8'b0);

        // 6: P=3 too small for both; P=4 fine for 3 samples (window 1..3), too small for 5
        clear_logs();
        for (int i = 0; i < 20; i++) add_bit(3, i[0], -1, 2);
        idle(3, 2);
        play();
        chk_int("t6_p3_strobes_a", lg_bit[0].size(), 0);
        chk_int("t6_p3_strobes_b", lg_bit[1].size(), 0);
        chk("t6_p3_cfg_a", ce[0], 1'b1);
        chk("t6_p3_cfg_b", ce[1], 1'b1);
        clear_logs();
        idle(4, 2);
        for (int i = 0; i < 4; i++) add_bit(4, i[0], -1, 3);
        idle(4, 3);
        play();
        chk_log("t6a", 0, 4, 8'b1010, 8'b0);
        chk_int("t6_p4_strobes_b", lg_bit[1].size(), 0);
        chk("t6_p4_cfg_a", ce[0], 1'b0);
        chk("t6_p4_cfg_b", ce[1], 1'b1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
